counter_sweep_controller: RTL and testbench
===========================================

// Module: counter_sweep_controller
// PURPOSE
//  Sequencer for the adjustable-stepwidth up/down counter. Drives its upnotdown and stepwidth
//  inputs to produce triangle sweeps between lo_limit and hi_limit, with programmable dwell at
//  each turning point and an exact landing on each limit. Sits between the register/config
//  logic and the counter; the counter output is fed back only to seed the start position.
// PARAMETERS
//  WIDTH    16  counter / limit / step width
//  NSWP_W    8  width of sweep-count input
//  HOLD_W    8  width of dwell-cycle input
// PORTS
//  clk            in   1        rising-edge clock, shared with the counter
//  rst_n          in   1        asynchronous active-low reset
//  start          in   1        1-cycle request; sampled only in IDLE
//  abort          in   1        stop immediately; priority over everything except rst_n
//  lo_limit       in   WIDTH    lower turning point (unsigned)
//  hi_limit       in   WIDTH    upper turning point (unsigned)
//  step_in        in   WIDTH    nominal step per cycle
//  n_sweeps       in   NSWP_W   full lo->hi->lo sweeps to perform
//  hold_cycles    in   HOLD_W   dwell cycles at each limit (0 = no dwell)
//  count_in       in   WIDTH    counter output (current value)
//  upnotdown      out  1        to counter: 1 = add, 0 = subtract
//  stepwidth_out  out  WIDTH    to counter; 0 whenever not moving
//  busy           out  1        high from the cycle after start until return to IDLE
//  done           out  1        1-cycle pulse on normal completion
//  err            out  1        1-cycle pulse on rejected start
// BEHAVIOUR
//  Reset: state=IDLE, upnotdown=1, stepwidth_out=0, busy=0, done=0, err=0, pos=0, counters=0.
//  - All outputs are registered. The counter applies stepwidth_out on the edge after it is driven.
//  - Shadow register pos holds the commanded position and is updated on the same edge that loads
//    stepwidth_out.
//  - start in IDLE:
//    - lo_limit>hi_limit or step_in==0: err=1 for one cycle; stay IDLE.
//    - Otherwise latch all config inputs, set pos=count_in, busy=1, go to SEEK.
//  - start while busy: ignored. Config input changes while busy: ignored.
//  - Move step (SEEK/UP/DOWN): rem=|target-pos|; step=min(step_in,rem); drive stepwidth_out=step
//    with the direction toward target, pos<=pos±step. A limit is therefore hit exactly and never
//    overshot. The counter never saturates in normal use.
//  - States:
//    - IDLE: stepwidth_out=0.
//    - SEEK: target=lo_limit; direction is up if pos<lo, else down. When rem==0 (pos==lo_limit),
//      drive 0. If n_sweeps==0 go to FIN, else go to UP.
//    - UP: target=hi_limit. When pos reaches hi_limit go to HOLD_HI (or DOWN if hold_cycles==0).
//    - HOLD_HI: stepwidth_out=0 for exactly hold_cycles cycles, then go to DOWN.
//    - DOWN: target=lo_limit. On arrival increment the sweep counter. If it equals n_sweeps go to
//      FIN, else go to HOLD_LO (or UP if hold_cycles==0).
//    - HOLD_LO: same as HOLD_HI, then go to UP.
//    - FIN: stepwidth_out=0 for one cycle so the counter applies the last step. Then done=1 and
//      busy=0 in the same cycle; go to IDLE.
//  - lo_limit==hi_limit: UP and DOWN take zero move cycles; dwell and sweep counting still apply.
//  - upnotdown holds its last value while stepwidth_out==0.
//  - abort (any state): next edge stepwidth_out=0, busy=0, state=IDLE, no done. Any step already
//    driven is still applied by the counter.
//  - rst_n low mid-sweep: immediate return to reset values. Counter state is not owned here.
//  - Arithmetic is WIDTH-bit unsigned. rem is computed with compare-then-subtract, never wraps.
// TESTING
//  1. count=0, lo=10, hi=40, step=7, n=1, hold=0 -> step sequence 7,3 | 7,7,7,7,2 | 7,7,7,7,2;
//     ends at 10; done once.
//  2. Same as 1 with hold=3 -> exactly 3 zero-step cycles at 40; no dwell before FIN; done after
//     final 10.
//  3. lo=50, hi=20 -> err pulse next cycle, busy stays 0, stepwidth_out stays 0. Same for
//     step_in=0.
//  4. count=100, lo=5, hi=8, step=1000, n=2 -> one down step of 95, then 3,3,3,3 alternating;
//     finishes at 5.
//  5. abort mid-UP -> next cycle stepwidth_out=0, busy=0, no done; a new start resumes from
//     count_in.
//  6. Assert rst_n mid-DOWN -> all outputs at reset values asynchronously; start with n=0 only
//     seeks to lo, then done.

Source files
------------

// File: rtl/counter_sweep_controller_if.sv
// Control/status bundle between the config side, the sweep controller and the counter.
interface counter_sweep_controller_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NSWP_W = 8,
  parameter int unsigned HOLD_W = 8
);
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  lo_limit;
  logic [WIDTH-1:0]  hi_limit;
  logic [WIDTH-1:0]  step_in;
  logic [NSWP_W-1:0] n_sweeps;
  logic [HOLD_W-1:0] hold_cycles;
  logic [WIDTH-1:0]  count_in;
  logic              upnotdown;
  logic [WIDTH-1:0]  stepwidth_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, lo_limit, hi_limit, step_in, n_sweeps, hold_cycles, count_in,
    input  upnotdown, stepwidth_out, busy, done, err
  );

  modport slave (
    input  start, abort, lo_limit, hi_limit, step_in, n_sweeps, hold_cycles, count_in,
    output upnotdown, stepwidth_out, busy, done, err
  );
endinterface

// File: rtl/counter_sweep_controller.sv
// Sequencer driving an up/down counter through triangle sweeps between two limits,
// landing exactly on each limit with optional dwell at the turning points.
module counter_sweep_controller #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NSWP_W = 8,
  parameter int unsigned HOLD_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  counter_sweep_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO, S_FIN
  } state_t;

  state_t r_state, w_state_nxt;

  // registered outputs and internal state
  logic              r_upnotdown, w_upnotdown_nxt;
  logic [WIDTH-1:0]  r_sw, w_sw_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [WIDTH-1:0]  r_pos, w_pos_nxt;
  logic [NSWP_W-1:0] r_swp_cnt, w_swp_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;

  // configuration latched at start
  logic [WIDTH-1:0]  r_lo, w_lo_nxt;
  logic [WIDTH-1:0]  r_hi, w_hi_nxt;
  logic [WIDTH-1:0]  r_step, w_step_cfg_nxt;
  logic [NSWP_W-1:0] r_nswp, w_nswp_nxt;
  logic [HOLD_W-1:0] r_holdc, w_holdc_nxt;

  // move arithmetic
  logic [WIDTH-1:0]  w_target;
  logic [WIDTH-1:0]  w_rem;
  logic [WIDTH-1:0]  w_step;
  logic              w_dir;
  logic              w_arrive;
  logic              w_hold_last;
  logic [NSWP_W-1:0] w_swp_inc;
  logic              w_cfg_bad;

  assign bus.upnotdown     = r_upnotdown;
  assign bus.stepwidth_out = r_sw;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;

  // Remaining distance and clipped step toward the current target; compare before
  // subtracting so the distance never wraps.
  always_comb begin
    w_target = (r_state == S_UP) ? r_hi : r_lo;
    if (w_target >= r_pos) begin
      w_dir = 1'b1;
      w_rem = w_target - r_pos;
    end else begin
      w_dir = 1'b0;
      w_rem = r_pos - w_target;
    end
    w_step      = (r_step < w_rem) ? r_step : w_rem;
    w_arrive    = (w_step == w_rem);
    w_hold_last = (r_hold_cnt == (r_holdc - HOLD_W'(1)));
    w_swp_inc   = r_swp_cnt + NSWP_W'(1);
    w_cfg_bad   = (bus.lo_limit > bus.hi_limit) || (bus.step_in == '0);
  end

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_upnotdown <= 1'b1;
      r_sw        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pos       <= '0;
      r_swp_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_step      <= '0;
      r_nswp      <= '0;
      r_holdc     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_upnotdown <= w_upnotdown_nxt;
      r_sw        <= w_sw_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_pos       <= w_pos_nxt;
      r_swp_cnt   <= w_swp_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_step      <= w_step_cfg_nxt;
      r_nswp      <= w_nswp_nxt;
      r_holdc     <= w_holdc_nxt;
    end
  end

  // Next-state selection; abort overrides every state
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (bus.start && !w_cfg_bad) w_state_nxt = S_SEEK;
        S_SEEK:    if (w_rem == '0) w_state_nxt = (r_nswp == '0) ? S_FIN : S_UP;
        S_UP:      if (w_arrive) w_state_nxt = (r_holdc == '0) ? S_DOWN : S_HOLD_HI;
        S_HOLD_HI: if (w_hold_last) w_state_nxt = S_DOWN;
        S_DOWN: begin
          if (w_arrive) begin
            if (w_swp_inc == r_nswp)  w_state_nxt = S_FIN;
            else if (r_holdc == '0)   w_state_nxt = S_UP;
            else                      w_state_nxt = S_HOLD_LO;
          end
        end
        S_HOLD_LO: if (w_hold_last) w_state_nxt = S_UP;
        S_FIN:     w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of outputs, shadow position and counters
  always_comb begin
    w_upnotdown_nxt = r_upnotdown;
    w_sw_nxt        = '0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_pos_nxt       = r_pos;
    w_swp_cnt_nxt   = r_swp_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_lo_nxt        = r_lo;
    w_hi_nxt        = r_hi;
    w_step_cfg_nxt  = r_step;
    w_nswp_nxt      = r_nswp;
    w_holdc_nxt     = r_holdc;
    if (bus.abort) begin
      w_busy_nxt     = 1'b0;
      w_hold_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_cfg_bad) begin
              w_err_nxt = 1'b1;
            end else begin
              w_lo_nxt       = bus.lo_limit;
              w_hi_nxt       = bus.hi_limit;
              w_step_cfg_nxt = bus.step_in;
              w_nswp_nxt     = bus.n_sweeps;
              w_holdc_nxt    = bus.hold_cycles;
              w_pos_nxt      = bus.count_in;
              w_busy_nxt     = 1'b1;
              w_swp_cnt_nxt  = '0;
              w_hold_cnt_nxt = '0;
            end
          end
        end
        S_SEEK, S_UP, S_DOWN: begin
          if (w_step != '0) begin
            w_sw_nxt        = w_step;
            w_upnotdown_nxt = w_dir;
            w_pos_nxt       = w_dir ? (r_pos + w_step) : (r_pos - w_step);
          end
          if ((r_state == S_DOWN) && w_arrive) w_swp_cnt_nxt = w_swp_inc;
        end
        S_HOLD_HI, S_HOLD_LO: begin
          w_hold_cnt_nxt = w_hold_last ? '0 : (r_hold_cnt + HOLD_W'(1));
        end
        S_FIN: begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        default: w_busy_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sweep_controller.sv
// Directed bench: per-cycle expected outputs queued ahead of each run, then popped and
// compared every cycle; a behavioural counter closes the loop through count_in.
module tb_counter_sweep_controller;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NSWP_W = 8;
  localparam int unsigned HOLD_W = 8;

  typedef struct {
    logic [WIDTH-1:0] sw;
    logic             ud;
    logic             ud_chk;
    logic             busy;
    logic             done;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  string       tname  = "";
  exp_t        q[$];

  counter_sweep_controller_if #(.WIDTH(WIDTH), .NSWP_W(NSWP_W), .HOLD_W(HOLD_W)) bus ();

  counter_sweep_controller #(.WIDTH(WIDTH), .NSWP_W(NSWP_W), .HOLD_W(HOLD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.count_in = count;

  // behavioural counter: applies the step driven in the previous cycle
  always @(posedge clk) begin
    if (load)
      count <= load_val;
    else if (bus.stepwidth_out != '0)
      count <= bus.upnotdown ? (count + bus.stepwidth_out) : (count - bus.stepwidth_out);
  end

  task automatic ex(input int n, input logic [WIDTH-1:0] sw, input logic ud,
                    input logic busy, input logic done, input logic err);
    exp_t e;
    e.sw = sw; e.ud = ud; e.ud_chk = (sw != '0); e.busy = busy; e.done = done; e.err = err;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s %s cyc%0d observed=%0d expected=%0d", tname, tag, cyc, obs, expv);
    end
  endtask

  task automatic drain();
    exp_t e;
    cyc = 0;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e = q.pop_front();
      cyc++;
      chk("stepwidth", bus.stepwidth_out, e.sw);
      if (e.ud_chk) chk("upnotdown", WIDTH'(bus.upnotdown), WIDTH'(e.ud));
      chk("busy", WIDTH'(bus.busy), WIDTH'(e.busy));
      chk("done", WIDTH'(bus.done), WIDTH'(e.done));
      chk("err", WIDTH'(bus.err), WIDTH'(e.err));
    end
  endtask

  task automatic cfg(input int lo, input int hi, input int st, input int n, input int h);
    bus.lo_limit    = WIDTH'(lo);
    bus.hi_limit    = WIDTH'(hi);
    bus.step_in     = WIDTH'(st);
    bus.n_sweeps    = NSWP_W'(n);
    bus.hold_cycles = HOLD_W'(h);
  endtask

  task automatic set_count(input int v);
    load = 1'b1;
    load_val = WIDTH'(v);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // standard 10..40 step 7 single sweep from an already-seeked position
  task automatic ex_sweep_10_40(input int hold);
    ex(4, 7, 1, 1, 0, 0); ex(1, 2, 1, 1, 0, 0);
    ex(hold, 0, 0, 1, 0, 0);
    ex(4, 7, 0, 1, 0, 0); ex(1, 2, 0, 1, 0, 0);
    ex(1, 0, 0, 0, 1, 0);
    ex(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    load_val = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(0, 0, 0, 0, 0);
    set_count(0);
    @(posedge clk);
    #1;
    tname = "reset";
    chk("stepwidth", bus.stepwidth_out, '0);
    chk("upnotdown", WIDTH'(bus.upnotdown), WIDTH'(1));
    chk("busy", WIDTH'(bus.busy), '0);
    chk("done", WIDTH'(bus.done), '0);
    chk("err", WIDTH'(bus.err), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic sweep, no dwell
    tname = "t1";
    set_count(0);
    cfg(10, 40, 7, 1, 0);
    bus.start = 1'b1;
    ex(1, 0, 0, 1, 0, 0); ex(1, 7, 1, 1, 0, 0); ex(1, 3, 1, 1, 0, 0); ex(1, 0, 0, 1, 0, 0);
    ex_sweep_10_40(0);
    drain();
    chk("count_end", count, 16'd10);

    // 2: dwell of 3 at the top only
    tname = "t2";
    set_count(0);
    cfg(10, 40, 7, 1, 3);
    bus.start = 1'b1;
    ex(1, 0, 0, 1, 0, 0); ex(1, 7, 1, 1, 0, 0); ex(1, 3, 1, 1, 0, 0); ex(1, 0, 0, 1, 0, 0);
    ex_sweep_10_40(3);
    drain();
    chk("count_end", count, 16'd10);

    // 3: rejected starts
    tname = "t3_lohi";
    cfg(50, 20, 7, 1, 0);
    bus.start = 1'b1;
    ex(1, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 0, 0);
    drain();
    tname = "t3_step0";
    cfg(10, 40, 0, 1, 0);
    bus.start = 1'b1;
    ex(1, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 0, 0);
    drain();

    // 4: large step clipped to the limit distance
    tname = "t4";
    set_count(100);
    cfg(5, 8, 1000, 2, 0);
    bus.start = 1'b1;
    ex(1, 0, 0, 1, 0, 0); ex(1, 95, 0, 1, 0, 0); ex(1, 0, 0, 1, 0, 0);
    ex(1, 3, 1, 1, 0, 0); ex(1, 3, 0, 1, 0, 0); ex(1, 3, 1, 1, 0, 0); ex(1, 3, 0, 1, 0, 0);
    ex(1, 0, 0, 0, 1, 0); ex(1, 0, 0, 0, 0, 0);
    drain();
    chk("count_end", count, 16'd5);

    // 5: abort mid-UP, then restart from where the counter stopped
    tname = "t5_abort";
    set_count(0);
    cfg(10, 40, 7, 1, 0);
    bus.start = 1'b1;
    ex(1, 0, 0, 1, 0, 0); ex(1, 7, 1, 1, 0, 0); ex(1, 3, 1, 1, 0, 0); ex(1, 0, 0, 1, 0, 0);
    ex(2, 7, 1, 1, 0, 0);
    drain();
    bus.abort = 1'b1;
    ex(1, 0, 0, 0, 0, 0);
    drain();
    bus.abort = 1'b0;
    ex(2, 0, 0, 0, 0, 0);
    drain();
    chk("count_abort", count, 16'd24);
    tname = "t5_restart";
    bus.start = 1'b1;
    ex(1, 0, 0, 1, 0, 0); ex(2, 7, 0, 1, 0, 0); ex(1, 0, 0, 1, 0, 0);
    ex_sweep_10_40(0);
    drain();
    chk("count_end", count, 16'd10);

    // 6: reset mid-DOWN, then a seek-only run
    tname = "t6_rst";
    bus.start = 1'b1;
    ex(2, 0, 0, 1, 0, 0); ex(4, 7, 1, 1, 0, 0); ex(1, 2, 1, 1, 0, 0); ex(2, 7, 0, 1, 0, 0);
    drain();
    rst_n = 1'b0;
    #1;
    chk("stepwidth", bus.stepwidth_out, '0);
    chk("upnotdown", WIDTH'(bus.upnotdown), WIDTH'(1));
    chk("busy", WIDTH'(bus.busy), '0);
    chk("done", WIDTH'(bus.done), '0);
    chk("count_at_rst", count, 16'd33);
    #2;
    rst_n = 1'b1;
    tname = "t6_seek";
    cfg(10, 40, 7, 0, 0);
    bus.start = 1'b1;
    ex(1, 0, 0, 1, 0, 0); ex(3, 7, 0, 1, 0, 0); ex(1, 2, 0, 1, 0, 0); ex(1, 0, 0, 1, 0, 0);
    ex(1, 0, 0, 0, 1, 0); ex(1, 0, 0, 0, 0, 0);
    drain();
    chk("count_end", count, 16'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
